// File: rtl/bus16_bridge.sv
// bus16_bridge: splits each 32-bit core request into one or two 16-bit
// transfers, low half first, and reassembles read data. The core sees a
// single s_ready pulse per request. All outputs are registered.
module bus16_bridge #(
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic [31:0] s_rdata,
  input  logic        s_wr,
  input  logic [3:0]  s_lane,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic        m_wr,
  output logic [1:0]  m_lane,
  output logic        m_valid,
  input  logic        m_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;

  // Latched request: only the fields still needed after acceptance.
  logic [29:0] req_word;
  logic [15:0] req_wdata_hi;
  logic [1:0]  req_lane_hi;
  logic        req_wr;
  logic        need_hi;
  logic [15:0] lo_half;
  logic [15:0] hi_half;

  // Half-selection decisions for the request being offered in IDLE.
  logic        acc_need_lo;
  logic        acc_need_hi;
  logic [1:0]  acc_lane_lo;
  logic [1:0]  acc_lane_hi;

  assign acc_need_lo = !s_wr || !SKIP_EMPTY || (|s_lane[1:0]);
  assign acc_need_hi = !s_wr || !SKIP_EMPTY || (|s_lane[3:2]);
  // Reads always move full halves regardless of the core's byte enables.
  assign acc_lane_lo = s_wr ? s_lane[1:0] : 2'b11;
  assign acc_lane_hi = s_wr ? s_lane[3:2] : 2'b11;

  // The byte offset within the word never reaches the 16-bit side.
  logic unused_bits;
  assign unused_bits = ^s_addr[1:0];

  // Request sequencer: accept, issue low/high halves, then pulse s_ready.
  always_ff @(posedge clk) begin
    // NOTE: every register here, including data and the read halves, is
    // cleared on reset so a mid-transfer reset leaves no stale state visible.
    if (rst) begin
      state        <= IDLE;
      s_ready      <= 1'b0;
      s_rdata      <= '0;
      m_valid      <= 1'b0;
      m_wr         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_lane       <= 2'b00;
      req_word     <= '0;
      req_wdata_hi <= '0;
      req_lane_hi  <= 2'b00;
      req_wr       <= 1'b0;
      need_hi      <= 1'b0;
      lo_half      <= '0;
      hi_half      <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every branch sees the
      // register values from before this edge.
      case (state)
        IDLE: begin
          s_ready <= 1'b0;
          if (s_valid) begin
            req_word     <= s_addr[31:2];
            req_wdata_hi <= s_wdata[31:16];
            req_lane_hi  <= acc_lane_hi;
            req_wr       <= s_wr;
            need_hi      <= acc_need_hi;
            m_wr         <= s_wr;
            if (acc_need_lo) begin
              state   <= LO;
              m_valid <= 1'b1;
              m_addr  <= {s_addr[31:2], 2'b00};
              m_wdata <= s_wdata[15:0];
              m_lane  <= acc_lane_lo;
            end else if (acc_need_hi) begin
              state   <= HI;
              m_valid <= 1'b1;
              m_addr  <= {s_addr[31:2], 2'b10};
              m_wdata <= s_wdata[31:16];
              m_lane  <= acc_lane_hi;
            end else begin
              // Empty write: nothing to move, complete immediately.
              state   <= RESP;
              s_ready <= 1'b1;
            end
          end
        end

        LO: begin
          if (m_ready) begin
            if (!req_wr) begin
              lo_half <= m_rdata;
            end
            if (need_hi) begin
              // m_valid stays high; only the transfer fields advance.
              state   <= HI;
              m_addr  <= {req_word, 2'b10};
              m_wdata <= req_wdata_hi;
              m_lane  <= req_lane_hi;
            end else begin
              state   <= RESP;
              m_valid <= 1'b0;
              s_ready <= 1'b1;
            end
          end
        end

        HI: begin
          if (m_ready) begin
            if (!req_wr) begin
              hi_half <= m_rdata;
              s_rdata <= {m_rdata, lo_half};
            end
            state   <= RESP;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end

        RESP: begin
          s_ready <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
